// File: rtl/ring_ctrl_pkg.sv
// Shared state encoding, default timing constants and width helpers for the
// alarm ring controller and its phase timer.
package ring_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RING_ON  = 2'd1,
        ST_RING_OFF = 2'd2,
        ST_SNOOZE   = 2'd3
    } ring_state_e;

    localparam int DEF_ON_TICKS     = 2;
    localparam int DEF_OFF_TICKS    = 1;
    localparam int DEF_MAX_CYCLES   = 30;
    localparam int DEF_SNOOZE_TICKS = 300;
    localparam int DEF_MAX_SNOOZES  = 3;

    // Width needed to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick-enabled phase counter: counts ticks since the last clear and flags the
// tick that completes the current limit.
module tick_timer
    import ring_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_tick,
    input  logic         i_clear,
    input  logic [W-1:0] i_limit,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Done fires on the tick that would bring the count up to the limit.
    assign o_done = i_tick && (r_cnt == i_limit - W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing sequencer: bursts of tone with silences, user snooze/dismiss,
// and automatic timeout after a fixed number of burst cycles.
module alarm_ring_ctrl
    import ring_ctrl_pkg::*;
#(
    parameter int ON_TICKS     = DEF_ON_TICKS,
    parameter int OFF_TICKS    = DEF_OFF_TICKS,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS,
    parameter int MAX_SNOOZES  = DEF_MAX_SNOOZES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tick,
    input  logic                                trigger,
    input  logic                                snooze,
    input  logic                                dismiss,
    output logic                                ring_on,
    output logic                                active,
    output logic                                snoozing,
    output logic [cnt_width(MAX_SNOOZES)-1:0]   snooze_cnt,
    output logic                                missed
);

    localparam int SNZ_W = cnt_width(MAX_SNOOZES);
    localparam int CYC_W = cnt_width(MAX_CYCLES);
    localparam int PH_W  = cnt_width(max3(ON_TICKS, OFF_TICKS, SNOOZE_TICKS));

    ring_state_e      r_state, w_next;
    logic [CYC_W-1:0] r_cyc, w_cyc_next;
    logic [SNZ_W-1:0] r_snz, w_snz_next;
    logic             r_ring_on, r_active, r_snoozing, r_missed;
    logic             w_timeout, w_done, w_phase_clear, w_snz_ok;
    logic [PH_W-1:0]  w_limit;

    assign w_snz_ok = (r_snz < SNZ_W'(MAX_SNOOZES));

    always_comb begin
        case (r_state)
            ST_RING_OFF: w_limit = PH_W'(OFF_TICKS);
            ST_SNOOZE:   w_limit = PH_W'(SNOOZE_TICKS);
            default:     w_limit = PH_W'(ON_TICKS);
        endcase
    end

    tick_timer #(.W(PH_W)) u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (tick),
        .i_clear (w_phase_clear),
        .i_limit (w_limit),
        .o_done  (w_done)
    );

    // Branch order inside each state encodes dismiss > snooze > tick > trigger.
    always_comb begin
        w_next     = r_state;
        w_cyc_next = r_cyc;
        w_snz_next = r_snz;
        w_timeout  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (trigger) begin
                    w_next     = ST_RING_ON;
                    w_cyc_next = '0;
                end
            end
            ST_RING_ON: begin
                if (dismiss) begin
                    w_next = ST_IDLE;
                end else if (snooze && w_snz_ok) begin
                    w_next     = ST_SNOOZE;
                    w_snz_next = r_snz + SNZ_W'(1);
                end else if (w_done) begin
                    w_next = ST_RING_OFF;
                end
            end
            ST_RING_OFF: begin
                if (dismiss) begin
                    w_next = ST_IDLE;
                end else if (snooze && w_snz_ok) begin
                    w_next     = ST_SNOOZE;
                    w_snz_next = r_snz + SNZ_W'(1);
                end else if (w_done) begin
                    if (r_cyc == CYC_W'(MAX_CYCLES - 1)) begin
                        w_next    = ST_IDLE;
                        w_timeout = 1'b1;
                    end else begin
                        w_next     = ST_RING_ON;
                        w_cyc_next = r_cyc + CYC_W'(1);
                    end
                end
            end
            ST_SNOOZE: begin
                if (dismiss) begin
                    w_next = ST_IDLE;
                end else if (w_done) begin
                    w_next     = ST_RING_ON;
                    w_cyc_next = '0;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_next == ST_IDLE) begin
            w_cyc_next = '0;
            w_snz_next = '0;
        end
    end

    assign w_phase_clear = (w_next != r_state) || (r_state == ST_IDLE);

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cyc      <= '0;
            r_snz      <= '0;
            r_ring_on  <= 1'b0;
            r_active   <= 1'b0;
            r_snoozing <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cyc      <= w_cyc_next;
            r_snz      <= w_snz_next;
            r_ring_on  <= (w_next == ST_RING_ON);
            r_active   <= (w_next != ST_IDLE);
            r_snoozing <= (w_next == ST_SNOOZE);
            r_missed   <= w_timeout;
        end
    end

    assign ring_on    = r_ring_on;
    assign active     = r_active;
    assign snoozing   = r_snoozing;
    assign snooze_cnt = r_snz;
    assign missed     = r_missed;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Randomized and directed bench for alarm_ring_ctrl against a countdown-style
// reference model of the ringing rules.
module tb_alarm_ring_ctrl;

    localparam int ON_T  = 2;
    localparam int OFF_T = 1;
    localparam int MAX_C = 3;
    localparam int SNZ_T = 4;
    localparam int MAX_S = 2;

    localparam int P_IDLE = 0;
    localparam int P_ON   = 1;
    localparam int P_OFF  = 2;
    localparam int P_SNZ  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, trigger = 1'b0, snooze = 1'b0, dismiss = 1'b0;
    logic       ring_on, active, snoozing, missed;
    logic [1:0] snooze_cnt;

    int errors = 0;
    int checks = 0;
    int clk_cnt = 0;
    int missed_seen = 0;

    // model: phase, ticks left in phase, completed burst cycles, snoozes used
    int m_phase = P_IDLE;
    int m_left = 0;
    int m_cycles = 0;
    int m_snz = 0;
    bit m_missed = 1'b0;

    logic [5:0] exp_q[$];

    alarm_ring_ctrl #(
        .ON_TICKS     (ON_T),
        .OFF_TICKS    (OFF_T),
        .MAX_CYCLES   (MAX_C),
        .SNOOZE_TICKS (SNZ_T),
        .MAX_SNOOZES  (MAX_S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .trigger    (trigger),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .ring_on    (ring_on),
        .active     (active),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_left   = 0;
        m_cycles = 0;
        m_snz    = 0;
        m_missed = 1'b0;
    endtask

    task automatic model_update(input bit t, input bit tr, input bit sn, input bit di);
        m_missed = 1'b0;
        if (m_phase == P_IDLE) begin
            if (tr) begin
                m_phase  = P_ON;
                m_left   = ON_T;
                m_cycles = 0;
            end
        end else if (di) begin
            m_phase = P_IDLE;
            m_snz   = 0;
        end else if (sn && m_phase != P_SNZ && m_snz < MAX_S) begin
            m_snz++;
            m_phase = P_SNZ;
            m_left  = SNZ_T;
        end else if (t) begin
            m_left--;
            if (m_left == 0) begin
                if (m_phase == P_ON) begin
                    m_phase = P_OFF;
                    m_left  = OFF_T;
                end else if (m_phase == P_OFF) begin
                    m_cycles++;
                    if (m_cycles == MAX_C) begin
                        m_phase  = P_IDLE;
                        m_snz    = 0;
                        m_missed = 1'b1;
                    end else begin
                        m_phase = P_ON;
                        m_left  = ON_T;
                    end
                end else begin
                    m_phase  = P_ON;
                    m_left   = ON_T;
                    m_cycles = 0;
                end
            end
        end
        exp_q.push_back({m_phase == P_ON, m_phase != P_IDLE, m_phase == P_SNZ,
                         2'(m_snz), m_missed});
    endtask

    task automatic step(input bit tr, input bit sn, input bit di);
        bit t;
        logic [5:0] e;
        t = (clk_cnt % 4 == 3);
        tick = t; trigger = tr; snooze = sn; dismiss = di;
        @(posedge clk);
        clk_cnt++;
        model_update(t, tr, sn, di);
        #1;
        tick = 1'b0; trigger = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        e = exp_q.pop_front();
        check("ring_on", 32'(ring_on), 32'(e[5]));
        check("active", 32'(active), 32'(e[4]));
        check("snoozing", 32'(snoozing), 32'(e[3]));
        check("snooze_cnt", 32'(snooze_cnt), 32'(e[2:1]));
        check("missed", 32'(missed), 32'(e[0]));
        if (missed === 1'b1) missed_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int ph, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_phase == ph) begin
                ok = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 1'b0);
        end
        if (m_phase == ph) ok = 1'b1;
        check("reach_phase", 32'(ok), 32'd1);
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ring_on", 32'(ring_on), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_snoozing", 32'(snoozing), 32'd0);
        check("rst_snooze_cnt", 32'(snooze_cnt), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);
        rst_n = 1'b1;
        run(3);

        // full ring to auto-timeout
        base = missed_seen;
        step(1'b1, 1'b0, 1'b0);
        check("trig_ring_on", 32'(ring_on), 32'd1);
        run(50);
        check("timeout_missed_once", 32'(missed_seen - base), 32'd1);
        check("timeout_idle", 32'(active), 32'd0);

        // snooze in first burst, then three fresh cycles to timeout
        base = missed_seen;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("snz_state", 32'(snoozing), 32'd1);
        check("snz_cnt1", 32'(snooze_cnt), 32'd1);
        run(70);
        check("snz_then_timeout", 32'(missed_seen - base), 32'd1);

        // third snooze ignored
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run_until(P_ON, 40);
        step(1'b0, 1'b1, 1'b0);
        run_until(P_ON, 40);
        step(1'b0, 1'b1, 1'b0);
        check("snz_saturate", 32'(snooze_cnt), 32'd2);
        check("snz_still_active", 32'(active), 32'd1);
        check("snz_third_no_snooze", 32'(snoozing), 32'd0);

        // trigger while ringing and while snoozed changes nothing
        step(1'b1, 1'b0, 1'b0);
        run(2);
        step(1'b0, 1'b0, 1'b1);

        // dismiss in RING_OFF
        base = missed_seen;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_until(P_OFF, 40);
        step(1'b0, 1'b0, 1'b1);
        check("dismiss_off_idle", 32'(active), 32'd0);
        check("dismiss_off_cnt", 32'(snooze_cnt), 32'd0);

        // dismiss and snooze together
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("dis_snz_idle", 32'(active), 32'd0);
        check("dis_no_missed", 32'(missed_seen - base), 32'd0);

        // asynchronous reset mid-burst
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ring_on", 32'(ring_on), 32'd0);
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_cnt", 32'(snooze_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(6);
        step(1'b1, 1'b0, 1'b0);
        check("post_rst_trigger", 32'(ring_on), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
